// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with shared frame counter and per-frame slew limiting
module servo_pwm_multi #(
  parameter int NUM_CH      = 4,
  parameter int PERIOD_CYC  = 1_000_000,
  parameter int MIN_CYC     = 50_000,
  parameter int MAX_CYC     = 250_000,
  parameter int LSB_CYC     = 784,
  parameter int POS_W       = 8,
  parameter int SLEW_CYC    = 5_000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W      = $clog2(PERIOD_CYC),
  localparam int WID_W      = $clog2(MAX_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [POS_W-1:0]  wr_pos,
  input  logic [NUM_CH-1:0] en_i,
  output logic [NUM_CH-1:0] servo_o,
  output logic              frame_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
  localparam logic [WID_W-1:0] MIN_W    = WID_W'(MIN_CYC);
  localparam logic [WID_W-1:0] MAX_W    = WID_W'(MAX_CYC);
  localparam logic [WID_W-1:0] SLEW_W   = WID_W'(SLEW_CYC);
  localparam int               PROD_W   = POS_W + 32;

  logic [CNT_W-1:0]  r_cnt;
  logic [WID_W-1:0]  r_tgt [NUM_CH];
  logic [WID_W-1:0]  r_cur [NUM_CH];
  logic [NUM_CH-1:0] r_en_q;
  logic [NUM_CH-1:0] r_servo;
  logic              r_frame;
  logic              r_busy;
  logic              r_err;

  logic              w_upd;
  logic              w_acc;
  logic              w_ch_bad;
  logic [PROD_W-1:0] w_width_full;
  logic [WID_W-1:0]  w_width;
  logic [WID_W-1:0]  w_cur_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_busy_vec;
  logic [NUM_CH-1:0] w_servo_nxt;

  // The last cycle of each frame is the update cycle; writes are held off there.
  assign w_upd    = (r_cnt == LAST_CNT);
  assign wr_ready = ~w_upd;
  assign w_acc    = wr_valid & wr_ready;
  assign w_ch_bad = (32'(wr_ch) >= NUM_CH);

  // Full-width mapping so a large position cannot wrap below the clamp.
  assign w_width_full = PROD_W'(MIN_CYC) + PROD_W'(wr_pos) * PROD_W'(LSB_CYC);
  assign w_width      = (w_width_full > PROD_W'(MAX_CYC)) ? MAX_W : w_width_full[WID_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_upd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cur_nxt[i] = r_tgt[i];
      if (SLEW_CYC != 0) begin
        if (r_tgt[i] > r_cur[i]) begin
          if (32'(r_tgt[i] - r_cur[i]) > SLEW_CYC) begin
            w_cur_nxt[i] = r_cur[i] + SLEW_W;
          end
        end else if (32'(r_cur[i] - r_tgt[i]) > SLEW_CYC) begin
          w_cur_nxt[i] = r_cur[i] - SLEW_W;
        end
      end
    end
  end

  // Disabled channels keep tracking writes and slewing; only their output is gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_tgt[i] <= MIN_W;
        r_cur[i] <= MIN_W;
      end
      r_en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_acc && (wr_ch == CH_W'(i))) begin
          r_tgt[i] <= w_width;
        end
        if (w_upd) begin
          r_cur[i] <= w_cur_nxt[i];
        end
      end
      if (w_upd) begin
        r_en_q <= en_i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_busy_vec[i]  = r_en_q[i] && (r_cur[i] != r_tgt[i]);
      w_servo_nxt[i] = r_en_q[i] && (32'(r_cnt) < 32'(r_cur[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_servo <= '0;
      r_frame <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_servo <= w_servo_nxt;
      r_frame <= w_upd;
      r_busy  <= |w_busy_vec;
      r_err   <= w_acc && w_ch_bad;
    end
  end

  assign servo_o = r_servo;
  assign frame_o = r_frame;
  assign busy_o  = r_busy;
  assign err_o   = r_err;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - randomized frame-level check of servo_pwm_multi against a behavioural model
module tb_servo_pwm_multi;

  localparam int NUM_CH     = 3;
  localparam int PERIOD_CYC = 200;
  localparam int MIN_CYC    = 20;
  localparam int MAX_CYC    = 150;
  localparam int LSB_CYC    = 1;
  localparam int POS_W      = 8;
  localparam int SLEW_CYC   = 15;
  localparam int CH_W       = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [POS_W-1:0]  wr_pos = '0;
  logic [NUM_CH-1:0] en_i = '0;
  logic [NUM_CH-1:0] servo_o;
  logic              frame_o;
  logic              busy_o;
  logic              err_o;

  servo_pwm_multi #(
    .NUM_CH(NUM_CH), .PERIOD_CYC(PERIOD_CYC), .MIN_CYC(MIN_CYC), .MAX_CYC(MAX_CYC),
    .LSB_CYC(LSB_CYC), .POS_W(POS_W), .SLEW_CYC(SLEW_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_pos(wr_pos), .en_i(en_i), .servo_o(servo_o),
    .frame_o(frame_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int                m_tgt [NUM_CH];
  int                m_cur [NUM_CH];
  bit                m_en  [NUM_CH];
  logic [NUM_CH-1:0] en_upd;
  bit                acc_pending;
  bit                exp_err;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_tgt[c] = MIN_CYC;
      m_cur[c] = MIN_CYC;
      m_en[c]  = 1'b0;
    end
  endfunction

  function automatic void model_update();
    int d;
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = en_upd[c];
      d = m_tgt[c] - m_cur[c];
      if (SLEW_CYC == 0 || (d <= SLEW_CYC && d >= -SLEW_CYC)) m_cur[c] = m_tgt[c];
      else m_cur[c] = m_cur[c] + ((d > 0) ? SLEW_CYC : -SLEW_CYC);
    end
  endfunction

  function automatic void model_write(input int ch, input int pos);
    int w;
    if (ch >= NUM_CH) begin
      exp_err = 1'b1;
    end else begin
      w = MIN_CYC + pos * LSB_CYC;
      m_tgt[ch] = (w > MAX_CYC) ? MAX_CYC : w;
    end
  endfunction

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int c = 0; c < NUM_CH; c++) if (m_en[c] && m_cur[c] != m_tgt[c]) b = 1'b1;
    return b;
  endfunction

  // Leaves the bench at the sample point of the first frame_o after reset release.
  task automatic reset_and_sync(input bit mid);
    int n;
    int highs;
    wr_valid = 1'b0;
    acc_pending = 1'b0;
    exp_err = 1'b0;
    if (mid) begin
      #2 rst_n = 1'b0;
      #1;
    end else begin
      rst_n = 1'b0;
      tick();
      tick();
      tick();
    end
    check("rst_servo", servo_o, 0);
    check("rst_frame", frame_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_ready", wr_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    highs = 0;
    do begin
      tick();
      n++;
      if (servo_o != '0) highs++;
    end while (!frame_o && n < 2 * PERIOD_CYC);
    check("rst_to_frame", n, PERIOD_CYC);
    check("first_frame_servo", highs, 0);
    model_reset();
    en_upd = en_i;
  endtask

  // Starts at the sample point of a frame_o cycle and ends at the next one.
  task automatic run_frame(input bit stim, input bit force_hold);
    int hi [NUM_CH];
    int first [NUM_CH];
    int last [NUM_CH];
    model_update();
    for (int c = 0; c < NUM_CH; c++) begin
      hi[c] = 0;
      first[c] = -1;
      last[c] = -1;
    end
    for (int p = 0; p < PERIOD_CYC; p++) begin
      if (p > 0) tick();
      if (acc_pending) begin
        wr_valid = 1'b0;
        acc_pending = 1'b0;
      end
      check("frame_o", frame_o, p == 0);
      check("wr_ready", wr_ready, p != PERIOD_CYC - 1);
      check("err_o", err_o, exp_err);
      exp_err = 1'b0;
      if (p == 190) check("busy_o", busy_o, model_busy());
      for (int c = 0; c < NUM_CH; c++) begin
        if (servo_o[c]) begin
          hi[c]++;
          if (first[c] < 0) first[c] = p;
          last[c] = p;
        end
      end
      if (stim) begin
        if (!wr_valid && ((p >= 5 && p <= 100 && $urandom_range(0, 19) == 0) ||
                          (p == PERIOD_CYC - 2 && $urandom_range(0, 3) == 0) ||
                          (p == PERIOD_CYC - 1 && $urandom_range(0, 3) == 0))) begin
          wr_valid = 1'b1;
          wr_ch = CH_W'($urandom_range(0, 3));
          wr_pos = POS_W'($urandom);
        end
        if ($urandom_range(0, 49) == 0) en_i[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      end
      if (force_hold && p == PERIOD_CYC - 1 && !wr_valid) begin
        wr_valid = 1'b1;
        wr_ch = 2'd0;
        wr_pos = 8'd100;
      end
      if (p == PERIOD_CYC - 1) en_upd = en_i;
      if (wr_valid && p != PERIOD_CYC - 1) begin
        model_write(int'(wr_ch), int'(wr_pos));
        acc_pending = 1'b1;
      end
    end
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("width_ch%0d", c), hi[c], m_en[c] ? m_cur[c] : 0);
      if (hi[c] > 0)
        check($sformatf("contig_ch%0d", c), (first[c] == 1) && (last[c] - first[c] + 1 == hi[c]), 1);
    end
  endtask

  task automatic preset_write(input int ch, input int pos);
    wr_valid = 1'b1;
    wr_ch = CH_W'(ch);
    wr_pos = POS_W'(pos);
  endtask

  initial begin
    logic [NUM_CH-1:0] exp_mask;
    en_i = 3'b001;
    reset_and_sync(1'b0);
    run_frame(1'b0, 1'b0);
    run_frame(1'b0, 1'b0);

    en_i = '1;
    preset_write(2, 255);
    run_frame(1'b0, 1'b0);
    preset_write(1, 3);
    run_frame(1'b0, 1'b0);
    preset_write(3, 40);
    run_frame(1'b0, 1'b0);
    for (int f = 0; f < 9; f++) run_frame(1'b0, 1'b0);

    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b0);
    for (int f = 0; f < 12; f++) run_frame(1'b0, 1'b0);

    for (int f = 0; f < 30; f++) run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);

    en_upd = en_i;
    model_update();
    for (int k = 0; k < 5; k++) tick();
    for (int c = 0; c < NUM_CH; c++) exp_mask[c] = m_en[c];
    check("pre_rst_servo", servo_o, exp_mask);
    en_i = NUM_CH'($urandom);
    reset_and_sync(1'b1);
    for (int f = 0; f < 3; f++) run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Parametrised multi-channel hobby-servo PWM generator, successor to the single-channel 3-position servo driver in the SoC peripheral set. It drives NUM_CH servo outputs from one shared frame counter. Each channel has a POS_W-bit position register loaded through a valid/ready write port, a linear position-to-pulse-width mapping and per-frame slew-rate limiting. Enables are glitch-free, and status is reported back to the CSR wrapper.

## Interface
Parameters:
- NUM_CH, 4, number of servo channels (1..16)
- PERIOD_CYC, 1_000_000, frame length in clk cycles (20 ms at 50 MHz)
- MIN_CYC, 50_000, pulse width for position 0
- MAX_CYC, 250_000, maximum pulse width (clamp)
- LSB_CYC, 784, pulse-width increment per position LSB
- POS_W, 8, position field width
- SLEW_CYC, 5_000, maximum width change per frame; 0 = no limit

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  position write request
- wr_ready  out  1  write port can accept
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel
- wr_pos  in  POS_W  new position
- en_i  in  NUM_CH  per-channel enable
- servo_o  out  NUM_CH  PWM outputs
- frame_o  out  1  one-cycle frame-start strobe
- busy_o  out  1  some enabled channel has not reached its target
- err_o  out  1  one-cycle strobe: write to nonexistent channel

## Operation
- Frame counter cnt counts 0..PERIOD_CYC-1 and wraps. Width is $clog2(PERIOD_CYC).
- Each channel holds tgt[i] (target width) and cur[i] (applied width). Both are $clog2(MAX_CYC+1) bits wide.
- Write acceptance: a write is accepted on the cycle where wr_valid && wr_ready.
  - On acceptance, tgt[wr_ch] = min(MIN_CYC + wr_pos*LSB_CYC, MAX_CYC).
  - The product is computed at full width before the clamp.
- wr_ch >= NUM_CH: the write is accepted and dropped, and err_o pulses for one cycle.
- wr_ready is 1 except on the update cycle (cnt == PERIOD_CYC-1), when it is 0.
- Update cycle (cnt == PERIOD_CYC-1), for every channel:
  - If SLEW_CYC == 0, cur <= tgt.
  - Else, if |tgt-cur| <= SLEW_CYC, cur <= tgt.
  - Else, cur moves toward tgt by exactly SLEW_CYC.
- Enable sampling: en_i is sampled into en_q only on the update cycle. Mid-frame enable changes never produce runt pulses.
- servo_o[i] (registered) = en_q[i] && (cnt < cur[i]).
- frame_o (registered) = 1 in the cycle after cnt == PERIOD_CYC-1.
- busy_o (registered) = OR over i of (en_q[i] && cur[i] != tgt[i]).
- A disabled channel still accepts writes and still slews cur. Only its output is gated.

## Timing
- Reset (asynchronous assert, synchronous release):
  - cnt=0, tgt[i]=cur[i]=MIN_CYC, en_q=0.
  - servo_o=0, frame_o=0, busy_o=0, err_o=0, wr_ready=1.
- Output latency: servo_o lags the compare by 1 cycle. Each enabled channel is high for exactly cur[i] consecutive cycles per frame, starting in the cycle after cnt==0.
- A write accepted in frame N affects the pulse of frame N+1 at the earliest.
- A write on the cycle before the update cycle still lands in that update.
- Slew progress: a step from 50_000 to 250_000 with SLEW_CYC=5_000 completes in 40 frames.
- Back-to-back writes to the same channel: the last accepted write wins.
- Reset asserted mid-frame: all outputs go low immediately. After release, the first frame_o arrives PERIOD_CYC cycles later.

## Test plan
- Reset, en_i=4'b0001, no writes -> from frame 2 onward, servo_o[0] is high for 50_000 cycles per 1_000_000-cycle frame; other channels stay 0; frame_o pulses every 1_000_000 cycles.
- Write ch1 pos=255 with SLEW_CYC=0, en_i=all -> next frame, servo_o[1] is high for 249_920 cycles; other channels stay at 50_000.
- Write ch2 pos=255 with default slew -> pulse widths 55_000, 60_000, … over successive frames; busy_o=1 until the frame where width reaches 249_920, then busy_o=0.
- Hold wr_valid=1 across the update cycle -> wr_ready=0 for exactly that one cycle; the write is accepted on the next cycle.
- Write wr_ch=5 with NUM_CH=4 -> err_o is a one-cycle pulse; no tgt changes.
- Toggle en_i[3] at mid-frame and while servo_o[3] is high -> the output changes only at the frame boundary; no pulse shorter than cur[3] appears.
